sc_stream_decoder: RTL and testbench
====================================

// Module: sc_stream_decoder
// PURPOSE
//   Stochastic-to-binary converter: the consuming end of the SC bitstream interface driven
//   by sc_multiplier and the other SC arithmetic blocks. Counts the 1s in a window of
//   2**WIDTH valid stream samples and presents the count as a binary value with a
//   valid/ready handshake. Sits at the output of an SC datapath, feeding binary logic.
// PARAMETERS
//   WIDTH  default 8  log2 of the window length; window N = 2**WIDTH samples (WIDTH >= 2)
// PORTS
//   clk        in   1         single clock; all state updates on the rising edge
//   rst_n      in   1         reset; synchronous, active-low
//   start      in   1         pulse: begin a conversion window (accepted in IDLE/DONE only)
//   in_valid   in   1         bit_in is a valid stream sample this cycle
//   bit_in     in   1         stochastic bitstream input
//   busy       out  1         1 while in ACCUM
//   out_valid  out  1         value holds a completed result
//   out_ready  in   1         downstream accepts value when out_valid & out_ready
//   value      out  WIDTH+2   result; unipolar: zero-extended ones count (0..N);
//                             bipolar (macro): signed two's complement 2*ones-N
// BEHAVIOUR
//   - Reset (rst_n=0 at an edge): state=IDLE, ones_cnt=0, sample_cnt=0, busy=0,
//     out_valid=0, value=0. Applies mid-window and mid-handshake; the partial result is discarded.
//   - Counters: ones_cnt is WIDTH+1 bits (must reach N); sample_cnt is WIDTH+1 bits. No saturation needed.
//   - FSM states IDLE, ACCUM, DONE:
//     IDLE : start=1 -> ACCUM; clear ones_cnt and sample_cnt. Stream samples are ignored.
//     ACCUM: each cycle with in_valid=1 -> sample_cnt+=1 and ones_cnt+=bit_in. Cycles with
//            in_valid=0 do not advance the window. start is ignored.
//            When the N-th valid sample is accepted, go to DONE on that edge. value is
//            registered from the final count, including that sample. out_valid=1 from
//            the next cycle. Latency: out_valid rises the cycle after the N-th sample.
//     DONE : value and out_valid are held stable until out_ready=1. Stream samples are dropped.
//            out_ready=1: out_valid drops next cycle and the FSM goes to IDLE. If start=1 in
//            the same cycle, it goes directly to ACCUM with cleared counters, so
//            back-to-back windows have no idle gap.
//            start=1 with out_ready=0: ignored.
//   - out_ready is a don't-care outside DONE. busy = (state==ACCUM).
//   - value changes only on entry to DONE or on reset. It is not cleared when the result
//     is consumed.
// CONFIGURATION
//   SC_DECODER_BIPOLAR_EN defined  : value = 2*ones_cnt - N as signed WIDTH+2 bits.
//                                    Range -N..+N. Decodes bipolar SC encoding x=(2p-1).
//   SC_DECODER_BIPOLAR_EN undefined: value = {1'b0, ones_cnt}, range 0..N (unipolar, x=p).
//   Timing, handshake and FSM are identical in both builds.
// TESTING  (WIDTH=4, N=16 unless noted)
//   1. start; 16 samples bit_in=1, in_valid=1 -> out_valid rises the cycle after the 16th
//      sample; value=16 (bipolar: +16).
//   2. start; 16 samples of alternating 1,0 -> value=8 (bipolar: 0). Then 16 zeros -> value=0
//      (bipolar: -16, i.e. 6'b110000).
//   3. start; 16 ones interleaved with in_valid=0 bubbles carrying bit_in=1 -> value=16.
//      Bubbles do not count; out_valid rises only after the 16th valid sample.
//   4. Result ready, out_ready=0 for 10 cycles while bit_in toggles -> value and out_valid
//      stable. Then out_ready=1 together with start=1 -> next cycle busy=1, out_valid=0,
//      and the new window counts from 0.
//   5. rst_n=0 for one edge after 7 valid samples -> busy=0, out_valid=0, value=0. start;
//      16 zeros -> value=0 (no residue).
//   6. Random: an LFSR stream with P(1)=p is fed through sc_multiplier and decoded with
//      WIDTH=8 -> value matches the bench's exact 1s count of the stream for 50 windows.

Source files
------------

// File: rtl/sc_stream_decoder_if.sv
// sc_stream_decoder_if
//   Bundles the stream-side and result-side handshake of the SC stream decoder.
//   master: the environment; it drives start, in_valid, bit_in and out_ready, and
//           observes busy, out_valid and value.
//   slave : the decoder; it drives busy, out_valid and value.
//   WIDTH : log2 of the window length. value is WIDTH+2 bits wide.
interface sc_stream_decoder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             in_valid;
    logic             bit_in;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] value;

    modport master (
        output start, in_valid, bit_in, out_ready,
        input  busy, out_valid, value
    );

    modport slave (
        input  start, in_valid, bit_in, out_ready,
        output busy, out_valid, value
    );
endinterface

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder
//   Stochastic-to-binary converter. It counts the 1s over a window of 2**WIDTH
//   valid bitstream samples and presents the count as a binary result, using a
//   valid/ready handshake.
//   Ports:
//     clk   : clock. All state changes on the rising edge.
//     rst_n : synchronous reset, active low.
//     bus   : sc_stream_decoder_if.slave, which carries the following signals.
//             start     : begins a window. It is accepted only in IDLE, or in DONE
//                         together with out_ready.
//             in_valid  : bit_in holds a valid sample this cycle.
//             bit_in    : the input bitstream.
//             busy      : high while a window is being accumulated.
//             out_valid : value holds a completed result.
//             out_ready : downstream accepts value.
//             value     : the result, WIDTH+2 bits.
//   Build option SC_DECODER_BIPOLAR_EN:
//     defined   : value = 2*ones - N, signed two's complement (bipolar decode).
//     undefined : value = ones count, zero-extended (unipolar decode).
module sc_stream_decoder #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sc_stream_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    // The sample index of the final sample in a window, which is N-1.
    localparam logic [WIDTH:0] LAST = {1'b0, {WIDTH{1'b1}}};

    state_t           state;
    logic [WIDTH:0]   ones_cnt;
    logic [WIDTH:0]   sample_cnt;
    logic [WIDTH:0]   ones_nxt;
    logic [WIDTH+1:0] result;
    logic             last;

    // This count includes the current sample, so the result registered on the
    // final edge already contains the N-th bit.
    assign ones_nxt = ones_cnt + {{WIDTH{1'b0}}, bus.bit_in};
    assign last     = bus.in_valid && (sample_cnt == LAST);

`ifdef SC_DECODER_BIPOLAR_EN
    localparam logic [WIDTH+1:0] NVAL = {2'b01, {WIDTH{1'b0}}};
    assign result = {ones_nxt, 1'b0} - NVAL;
`else
    assign result = {1'b0, ones_nxt};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ones_cnt      <= '0;
            sample_cnt    <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.value     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= ACCUM;
                        bus.busy   <= 1'b1;
                        ones_cnt   <= '0;
                        sample_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        ones_cnt   <= ones_nxt;
                        if (last) begin
                            state         <= DONE;
                            bus.busy      <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.value     <= result;
                        end
                    end
                end
                DONE: begin
                    // start is honoured only together with out_ready. In that case
                    // the next window begins with no idle cycle in between.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (bus.start) begin
                            state      <= ACCUM;
                            bus.busy   <= 1'b1;
                            ones_cnt   <= '0;
                            sample_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder
//   Randomised self-checking bench. It uses one WIDTH=4 decoder for the directed
//   window scenarios and one WIDTH=8 decoder for long random product streams.
//   Expected results come from counting the 1s of the accepted samples.
module tb_sc_stream_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sc_stream_decoder_if #(.WIDTH(4)) a4 ();
    sc_stream_decoder_if #(.WIDTH(8)) a8 ();

    sc_stream_decoder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(a4));
    sc_stream_decoder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(a8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      tag, obs, obs, exp, exp, $time);
    endtask

    // Expected value for a window of n samples containing the given number of 1s,
    // truncated to w+2 bits.
    function automatic logic [31:0] expv(input int ones, input int n, input int w);
        int v;
`ifdef SC_DECODER_BIPOLAR_EN
        v = 2 * ones - n;
`else
        v = ones;
`endif
        return 32'(v) & ((32'd1 << (w + 2)) - 32'd1);
    endfunction

    // Sample generator. Mode 0 gives all ones, 1 alternates 1,0, 2 gives all
    // zeros, and 3 is random.
    function automatic logic patbit(input int mode, input int i);
        case (mode)
            0: return 1'b1;
            1: return (i % 2) == 0;
            2: return 1'b0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Advances one clock. Outputs are sampled 1 ns after the edge, and inputs
    // change at that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic window4(input int mode, input bit bubbles, input bit do_start, input string tag);
        int   ones = 0;
        int   k = 0;
        int   guard = 0;
        logic b;
        if (do_start) begin
            a4.start = 1'b1;
            step();
            a4.start = 1'b0;
        end
        chk({tag, "_busy"}, a4.busy, 1);
        while (k < 16 && guard < 400) begin
            guard++;
            if (bubbles && $urandom_range(0, 2) == 0) begin
                a4.in_valid = 1'b0;
                a4.bit_in   = 1'b1;
                step();
                chk({tag, "_bubble_ov"}, a4.out_valid, 0);
            end else begin
                b = patbit(mode, k);
                ones += int'(b);
                k++;
                a4.in_valid = 1'b1;
                a4.bit_in   = b;
                step();
                chk({tag, "_ov"}, a4.out_valid, (k == 16) ? 1 : 0);
            end
        end
        chk({tag, "_guard"}, (guard < 400) ? 1 : 0, 1);
        a4.in_valid = 1'b0;
        a4.bit_in   = 1'b0;
        chk({tag, "_value"}, a4.value, expv(ones, 16, 4));
        chk({tag, "_busy_done"}, a4.busy, 0);
    endtask

    task automatic consume4(input string tag);
        logic [31:0] held;
        held = a4.value;
        a4.out_ready = 1'b1;
        step();
        a4.out_ready = 1'b0;
        chk({tag, "_ov_drop"}, a4.out_valid, 0);
        chk({tag, "_idle"}, a4.busy, 0);
        chk({tag, "_value_kept"}, a4.value, held);
    endtask

    task automatic window8(input bit do_start, input int pa, input int pb, input int w);
        int   ones = 0;
        int   k = 0;
        int   guard = 0;
        logic b;
        if (do_start) begin
            a8.start = 1'b1;
            step();
            a8.start = 1'b0;
        end
        while (k < 256 && guard < 2000) begin
            guard++;
            if ($urandom_range(0, 7) == 0) begin
                a8.in_valid = 1'b0;
                a8.bit_in   = 1'($urandom_range(0, 1));
                step();
            end else begin
                // The product of two independent unipolar streams, as formed by an SC multiplier.
                b = ($urandom_range(0, 255) < pa) && ($urandom_range(0, 255) < pb);
                ones += int'(b);
                k++;
                a8.in_valid = 1'b1;
                a8.bit_in   = b;
                step();
                if (k >= 255) chk($sformatf("w%0d_ov_k%0d", w, k), a8.out_valid, (k == 256) ? 1 : 0);
            end
        end
        chk($sformatf("w%0d_guard", w), (guard < 2000) ? 1 : 0, 1);
        a8.in_valid = 1'b0;
        chk($sformatf("w%0d_value", w), a8.value, expv(ones, 256, 8));
    endtask

    initial begin
        logic [31:0] held;
        bit          b2b;
        int          waitc;
        {a4.start, a4.in_valid, a4.bit_in, a4.out_ready} = 4'b0;
        {a8.start, a8.in_valid, a8.bit_in, a8.out_ready} = 4'b0;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", a4.busy, 0);
        chk("rst_ov", a4.out_valid, 0);
        chk("rst_value", a4.value, 0);
        chk("rst8_value", a8.value, 0);
        rst_n = 1'b1;

        // Samples arriving in IDLE must be ignored.
        a4.in_valid = 1'b1;
        a4.bit_in   = 1'b1;
        a4.out_ready = 1'b1;
        repeat (3) step();
        chk("idle_busy", a4.busy, 0);
        a4.out_ready = 1'b0;

        // Test 1: all ones.
        window4(0, 1'b0, 1'b1, "ones");
        consume4("ones");
        // Test 2: alternating samples, then all zeros.
        window4(1, 1'b0, 1'b1, "alt");
        consume4("alt");
        window4(2, 1'b0, 1'b1, "zeros");
        consume4("zeros");
        // Test 3: all ones with bubbles that carry bit_in=1.
        window4(0, 1'b1, 1'b1, "bubble");

        // Test 4: hold the result while the stream toggles and start is asserted.
        held = a4.value;
        for (int i = 0; i < 10; i++) begin
            a4.in_valid = 1'b1;
            a4.bit_in   = 1'(i % 2);
            a4.start    = 1'(i % 3 == 0);
            step();
            chk("hold_value", a4.value, held);
            chk("hold_ov", a4.out_valid, 1);
            chk("hold_busy", a4.busy, 0);
        end
        a4.in_valid  = 1'b0;
        a4.start     = 1'b1;
        a4.out_ready = 1'b1;
        step();
        a4.start     = 1'b0;
        a4.out_ready = 1'b0;
        chk("b2b_busy", a4.busy, 1);
        chk("b2b_ov", a4.out_valid, 0);
        chk("b2b_value_kept", a4.value, held);
        window4(1, 1'b1, 1'b0, "b2b");
        consume4("b2b");

        // Test 5: reset in the middle of a window.
        a4.start = 1'b1;
        step();
        a4.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a4.in_valid = 1'b1;
            a4.bit_in   = 1'b1;
            step();
        end
        a4.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_busy", a4.busy, 0);
        chk("mid_rst_ov", a4.out_valid, 0);
        chk("mid_rst_value", a4.value, 0);
        window4(2, 1'b0, 1'b1, "post_rst");
        consume4("post_rst");

        // A few random WIDTH=4 windows.
        for (int i = 0; i < 6; i++) begin
            window4(3, 1'b1, 1'b1, "rand4");
            consume4("rand4");
        end

        // Test 6: 50 random product-stream windows, with random consumer delay and back-to-back starts.
        b2b = 1'b0;
        for (int w = 0; w < 50; w++) begin
            window8(!b2b, $urandom_range(0, 256), $urandom_range(0, 256), w);
            held  = a8.value;
            waitc = $urandom_range(0, 3);
            for (int i = 0; i < waitc; i++) begin
                step();
                chk("w_hold", a8.value, held);
            end
            b2b = 1'($urandom_range(0, 1));
            a8.out_ready = 1'b1;
            a8.start     = b2b;
            step();
            a8.out_ready = 1'b0;
            a8.start     = 1'b0;
            chk("w_ov_drop", a8.out_valid, 0);
            chk("w_busy", a8.busy, 32'(b2b));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
